// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM encoding for the data-memory arbiter.
// LAST_ADDR / ACC_BYTES are also used by the data memory block.
package dmem_arbiter_pkg;

  localparam int DATA_WID  = 64;
  localparam int LAST_ADDR = 96;
  localparam int ACC_BYTES = 8;

  // Highest start address whose full access still lands inside the array.
  localparam logic [DATA_WID-1:0] MAX_ACC_ADDR = DATA_WID'(LAST_ADDR - ACC_BYTES + 1);

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the requester
// that did not win last time is chosen.
module dmem_arbiter_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer in front of the 64-bit data memory.
// Build option DMEM_ARB_RANGE_CHECK_EN rejects out-of-range accesses before they reach memory.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [DATA_WID-1:0] addr0,
  input  logic [DATA_WID-1:0] addr1,
  input  logic [DATA_WID-1:0] wdata0,
  input  logic [DATA_WID-1:0] wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [DATA_WID-1:0] rdata,
  output logic                err,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  output logic                mem_write_flag,
  output logic                mem_read_flag,
  input  logic [DATA_WID-1:0] mem_valM,
  input  logic                mem_dmem_error
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrate and capture the winner
  // ACCESS | memory address/data/flag driven for exactly one cycle
  // DONE   | one-cycle ack to the granted requester, rdata/err valid

  arb_state_e          state;
  logic                last_grant;
  logic                cap_we;
  logic                cap_id;
  logic                grant_valid;
  logic                grant_id;
  logic                sel_we;
  logic [DATA_WID-1:0] sel_addr;
  logic [DATA_WID-1:0] sel_wdata;
  logic                reject;

  dmem_arbiter_rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = grant_id ? we1    : we0;
  assign sel_addr  = grant_id ? addr1  : addr0;
  assign sel_wdata = grant_id ? wdata1 : wdata0;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign reject = (sel_addr > MAX_ACC_ADDR);
`else
  assign reject = 1'b0;
`endif

  // mem_addr / mem_wdata double as the captured request registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= ARB_IDLE;
      last_grant     <= 1'b1;
      cap_we         <= 1'b0;
      cap_id         <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata          <= '0;
      err            <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
    end else begin
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_id;
            cap_id     <= grant_id;
            cap_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            if (reject) begin
              // Rejected accesses never touch memory; ack straight away.
              state <= ARB_DONE;
              err   <= 1'b1;
              rdata <= '0;
              ack0  <= ~grant_id;
              ack1  <= grant_id;
            end else begin
              state          <= ARB_ACCESS;
              mem_write_flag <= sel_we;
              mem_read_flag  <= ~sel_we;
            end
          end
        end
        ARB_ACCESS: begin
          state <= ARB_DONE;
          err   <= mem_dmem_error;
          rdata <= cap_we ? '0 : mem_valM;
          ack0  <= ~cap_id;
          ack1  <= cap_id;
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
          err   <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model,
// byte-array memory stand-in, directed scenarios plus randomized traffic.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAXA = LAST_ADDR - ACC_BYTES + 1;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_write_flag, mem_read_flag, mem_dmem_error;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_valM;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
    .mem_valM(mem_valM), .mem_dmem_error(mem_dmem_error)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory stand-in: byte array, little-endian, errors on accesses past MAXA.
  logic [7:0] hmem    [0:LAST_ADDR];
  logic [7:0] ref_mem [0:LAST_ADDR];

  assign mem_dmem_error = (mem_addr > 64'(MAXA));

  always_comb begin
    mem_valM = '0;
    if (!mem_dmem_error)
      for (int k = 0; k < 8; k++) mem_valM[8*k +: 8] = hmem[int'(mem_addr[6:0]) + k];
  end

  initial begin
    for (int i = 0; i <= LAST_ADDR; i++) begin
      hmem[i]    = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    forever begin
      @(posedge CLK);
      if (mem_write_flag && !mem_dmem_error)
        for (int k = 0; k < 8; k++) hmem[int'(mem_addr[6:0]) + k] = mem_wdata[8*k +: 8];
    end
  end

  // Reference model: per-cycle expectations scheduled from each grant.
  typedef struct {
    logic ack0, ack1, err, wflag, rflag;
    logic [63:0] rdata, addr, wdata;
  } exp_t;

  exp_t sched [16];
  int   cyc = 0;

  function automatic logic [63:0] ref_word(input int a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[a + k];
    return w;
  endfunction

  initial begin
    int          free_at, g, a, pw_a;
    logic        lg, bad, w, pw_v;
    logic [63:0] ad, wd, pw_d;
    free_at = 0; lg = 1'b1; pw_v = 1'b0; pw_a = 0; pw_d = '0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        for (int i = 0; i < 16; i++) sched[i] = '{default: '0};
        lg = 1'b1; pw_v = 1'b0; free_at = 0;
      end else begin
        cyc++;
        if (pw_v) begin
          for (int k = 0; k < 8; k++) ref_mem[pw_a + k] = pw_d[8*k +: 8];
          pw_v = 1'b0;
        end
        if (cyc >= free_at && (req0 || req1)) begin
          if (req0 && req1) g = lg ? 0 : 1;
          else              g = req1 ? 1 : 0;
          lg  = (g == 1);
          w   = (g == 1) ? we1 : we0;
          ad  = (g == 1) ? addr1 : addr0;
          wd  = (g == 1) ? wdata1 : wdata0;
          bad = (ad > 64'(MAXA));
          a   = bad ? 0 : int'(ad);
          if (RCHK && bad) begin
            sched[cyc % 16].ack0  = (g == 0);
            sched[cyc % 16].ack1  = (g == 1);
            sched[cyc % 16].err   = 1'b1;
            sched[cyc % 16].rdata = '0;
            free_at = cyc + 2;
          end else begin
            sched[cyc % 16].wflag = w;
            sched[cyc % 16].rflag = !w;
            sched[cyc % 16].addr  = ad;
            sched[cyc % 16].wdata = wd;
            sched[(cyc + 1) % 16].ack0  = (g == 0);
            sched[(cyc + 1) % 16].ack1  = (g == 1);
            sched[(cyc + 1) % 16].err   = bad;
            sched[(cyc + 1) % 16].rdata = (w || bad) ? 64'h0 : ref_word(a);
            if (w && !bad) begin pw_v = 1'b1; pw_a = a; pw_d = wd; end
            free_at = cyc + 3;
          end
        end
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (!RST_N) begin
        chk("reset_outputs", {56'h0, ack0, ack1, err, mem_write_flag, mem_read_flag,
                              |rdata, |mem_addr, |mem_wdata}, 64'h0);
      end else begin
        e = sched[cyc % 16];
        chk("ack0", ack0, e.ack0);
        chk("ack1", ack1, e.ack1);
        chk("mem_write_flag", mem_write_flag, e.wflag);
        chk("mem_read_flag", mem_read_flag, e.rflag);
        if (e.ack0 || e.ack1) begin
          chk("err", err, e.err);
          chk("rdata", rdata, e.rdata);
        end
        if (e.wflag || e.rflag) chk("mem_addr", mem_addr, e.addr);
        if (e.wflag) chk("mem_wdata", mem_wdata, e.wdata);
        sched[cyc % 16] = '{default: '0};
      end
    end
  end

  // Directed-run recorder.
  int          nacks, wf_cnt, rf_cnt;
  int          ack_id [8];
  int          ack_t  [8];
  logic [63:0] ack_rd [8];
  logic        ack_er [8];

  task automatic run(input int n, input bit d0, input bit d1);
    nacks = 0; wf_cnt = 0; rf_cnt = 0;
    for (int t = 1; t <= n; t++) begin
      @(posedge CLK); #1;
      if (mem_write_flag) wf_cnt++;
      if (mem_read_flag)  rf_cnt++;
      if ((ack0 || ack1) && nacks < 8) begin
        ack_id[nacks] = ack1 ? 1 : 0;
        ack_t[nacks]  = t;
        ack_rd[nacks] = rdata;
        ack_er[nacks] = err;
        nacks++;
      end
      @(negedge CLK);
      if (ack0 && d0) req0 = 1'b0;
      if (ack1 && d1) req1 = 1'b0;
    end
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(9) == 0) return 64'($urandom_range(100, 90));
    return 64'($urandom_range(89, 0));
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ack", {ack0, ack1}, 64'h0);
    chk("rst_flags", {mem_write_flag, mem_read_flag}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Write then read back through requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd16; wdata0 = 64'h1122334455667788;
    run(4, 1, 0);
    chk("wr16_nacks", 64'(nacks), 64'd1);
    chk("wr16_id", 64'(ack_id[0]), 64'd0);
    chk("wr16_lat", 64'(ack_t[0]), 64'd2);
    chk("wr16_err", 64'(ack_er[0]), 64'd0);
    chk("wr16_wflag_cycles", 64'(wf_cnt), 64'd1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd16;
    run(4, 1, 0);
    chk("rd16_data", ack_rd[0], 64'h1122334455667788);
    chk("rd16_lat", 64'(ack_t[0]), 64'd2);
    chk("rd16_rflag_cycles", 64'(rf_cnt), 64'd1);

    // Loader write vs pipeline read of the same word, same cycle
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'd40; wdata1 = 64'hDEADBEEF00000001;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd40;
    run(7, 1, 1);
    chk("coh_nacks", 64'(nacks), 64'd2);
    chk("coh_first_id", 64'(ack_id[0]), 64'd1);
    chk("coh_read_data", ack_rd[1],
        (ack_id[0] == 1) ? 64'hDEADBEEF00000001 : 64'h8A8B88898E8F8C8D);
    chk("coh_second_lat", 64'(ack_t[1]), 64'd5);
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd40;
    run(4, 0, 1);
    chk("rd40_data", ack_rd[0], 64'hDEADBEEF00000001);

    // Contention: both held for 12 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd24;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd32;
    run(12, 0, 0);
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_nacks", 64'(nacks), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_id", 64'(ack_id[i]), 64'(i % 2));
      chk("cont_time", 64'(ack_t[i]), 64'(2 + 3 * i));
      chk("cont_data", ack_rd[i], (i % 2 == 0) ? 64'hBABBB8B9BEBFBCBD : 64'h8283808186878485);
    end
    run(3, 0, 0);

    // Highest legal address
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd89; wdata0 = 64'h0102030405060708;
    run(4, 1, 0);
    chk("a89_err", 64'(ack_er[0]), 64'd0);
    chk("a89_lat", 64'(ack_t[0]), 64'd2);
    chk("a89_byte96", 64'(hmem[96]), 64'h01);

    // Out-of-range access
`ifdef DMEM_ARB_RANGE_CHECK_EN
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd90; wdata0 = '1;
    run(4, 1, 0);
    chk("rng_lat", 64'(ack_t[0]), 64'd1);
    chk("rng_wflag_cycles", 64'(wf_cnt), 64'd0);
`else
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd97; wdata0 = '1;
    run(4, 1, 0);
    chk("rng_lat", 64'(ack_t[0]), 64'd2);
`endif
    chk("rng_err", 64'(ack_er[0]), 64'd1);
    chk("rng_rdata", ack_rd[0], 64'h0);
    for (int i = 90; i <= LAST_ADDR; i++) chk("rng_mem_bytes", 64'(hmem[i]), 64'(ref_mem[i]));

    // Reset during the ACCESS cycle of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd8; wdata0 = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge CLK); #1;
    chk("midrst_wflag_before", 64'(mem_write_flag), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_flags", {mem_write_flag, mem_read_flag}, 64'h0);
    chk("midrst_ack", {ack0, ack1}, 64'h0);
    req0 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_byte8", 64'(hmem[8]), 64'hAD);
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd8;
    run(7, 1, 1);
    chk("postrst_nacks", 64'(nacks), 64'd2);
    chk("postrst_first_id", 64'(ack_id[0]), 64'd0);
    chk("postrst_lat", 64'(ack_t[0]), 64'd2);

    // Requester 1 drops its read request during ACCESS
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd32;
    @(posedge CLK); #1;
    chk("drop_rflag", 64'(mem_read_flag), 64'd1);
    @(negedge CLK);
    req1 = 1'b0;
    run(5, 0, 0);
    chk("drop_nacks", 64'(nacks), 64'd1);
    chk("drop_id", 64'(ack_id[0]), 64'd1);
    chk("drop_data", ack_rd[0], 64'h8283808186878485);

    // Randomized traffic, hold-until-ack discipline
    for (int c = 0; c < 900; c++) begin
      @(negedge CLK);
      if (req0 && ack0) req0 = 1'b0;
      if (req1 && ack1) req1 = 1'b0;
      if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(1)); addr0 = rand_addr();
        wdata0 = {$urandom, $urandom};
      end
      if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(1)); addr1 = rand_addr();
        wdata1 = {$urandom, $urandom};
      end
    end
    for (int c = 0; c < 30 && (req0 || req1); c++) begin
      @(negedge CLK);
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    chk("drain_reqs", {62'h0, req0, req1}, 64'h0);
    repeat (5) @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
